gpio_spi_master: RTL and testbench

SPI master sequencer that drives the 16-bit register-access frame of the GPIO expander from an on-chip host. It accepts one register read or write at a time over a valid/ready request port and generates `ss`, `sclk` and `mosi`. It samples `miso` and returns the read byte on a one-cycle response strobe. It sits between a system-side controller and the expander's SPI pins, replacing bench-style bit-banging in integrated designs.

---
 rtl/gpio_spi_pkg.sv | 21 ++
 rtl/gpio_spi_if.sv | 30 +++
 rtl/gpio_spi_clkgen.sv | 56 +++++
 rtl/gpio_spi_master.sv | 139 +++++++++++++
 tb/tb_gpio_spi_master.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_spi_pkg.sv
// Shared types and constants for the GPIO-expander SPI master: frame geometry,
// sclk divider limits and the sequencer state encoding.
package gpio_spi_pkg;

  localparam int FRAME_BITS       = 16;
  localparam int WRITE_BIT        = 15;
  localparam int CLK_DIV_MIN      = 1;
  localparam int CLK_DIV_MAX      = 255;
  localparam int CLK_DIV_SYNC_MIN = 3;
  localparam int DIV_CNT_W        = 8;
  localparam int BIT_CNT_W        = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

endpackage

// File: rtl/gpio_spi_if.sv
// Host request/response port plus the expander's SPI pins.
// master = the sequencer, slave = host and expander side.
interface gpio_spi_if #(
  parameter int ADDR_WIDTH  = 7,
  parameter int PDATA_WIDTH = 8
);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [PDATA_WIDTH-1:0] req_wdata;
  logic                   resp_valid;
  logic [PDATA_WIDTH-1:0] resp_rdata;
  logic                   sclk;
  logic                   ss;
  logic                   mosi;
  logic                   miso;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, miso,
    output req_ready, resp_valid, resp_rdata, sclk, ss, mosi
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, miso,
    input  req_ready, resp_valid, resp_rdata, sclk, ss, mosi
  );

endinterface

// File: rtl/gpio_spi_clkgen.sv
// Half-period counter: paces every sequencer state in CLK_DIV-cycle slices,
// owns sclk and strobes rise_en/fall_en on the clk edge that toggles it.
module gpio_spi_clkgen
  import gpio_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic toggle_i,
  output logic half_done_o,
  output logic rise_en_o,
  output logic fall_en_o,
  output logic sclk_o
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 sclk_q, sclk_d;

  assign half_done_o = en_i && (cnt_q == CNT_LAST);
  assign rise_en_o   = half_done_o && toggle_i && !sclk_q;
  assign fall_en_o   = half_done_o && toggle_i && sclk_q;
  assign sclk_o      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (half_done_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_CNT_W'(1);
    end
    if (rise_en_o) begin
      sclk_d = 1'b1;
    end else if (fall_en_o) begin
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/gpio_spi_master.sv
// SPI mode-0 sequencer for the expander's 16-bit register frame.
// Define GPIO_SPI_MISO_SYNC_EN to synchronise miso and sample it on sclk falls.
module gpio_spi_master
  import gpio_spi_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int ADDR_WIDTH  = 7,
  parameter int PDATA_WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  gpio_spi_if.master bus
);

  if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_div_range_chk
    $error("gpio_spi_master: CLK_DIV out of range");
  end
  if (1 + ADDR_WIDTH + PDATA_WIDTH != FRAME_BITS) begin : g_frame_chk
    $error("gpio_spi_master: write flag + address + data must fill the frame");
  end

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  tx_q, tx_d;
  logic [PDATA_WIDTH-1:0] rx_q, rx_d;
  logic [PDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [BIT_CNT_W-1:0]   fall_cnt_q, fall_cnt_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   half_done, rise_en, fall_en, sclk, toggle;
  logic                   all_falls_done, last_fall, in_frame;
  logic                   rx_bit, capture_en;

`ifdef GPIO_SPI_MISO_SYNC_EN
  if (CLK_DIV < CLK_DIV_SYNC_MIN) begin : g_sync_div_chk
    $error("gpio_spi_master: synchronised miso needs CLK_DIV >= 3");
  end

  logic miso_meta_q, miso_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= bus.miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  // Synchronised data is only settled a full half-period after the rise.
  assign rx_bit     = miso_sync_q;
  assign capture_en = fall_en;
`else
  assign rx_bit     = bus.miso;
  assign capture_en = rise_en;
`endif

  assign all_falls_done = (fall_cnt_q == BIT_CNT_W'(FRAME_BITS));
  assign last_fall      = (fall_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
  assign in_frame       = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  // The final low half-period stays in SHIFT without toggling, then HOLD follows.
  assign toggle         = (state_q == SETUP) || ((state_q == SHIFT) && !all_falls_done);

  gpio_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .reset       (reset),
    .en_i        (state_q != IDLE),
    .toggle_i    (toggle),
    .half_done_o (half_done),
    .rise_en_o   (rise_en),
    .fall_en_o   (fall_en),
    .sclk_o      (sclk)
  );

  // NOTE: every variable gets its default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    rdata_d      = rdata_q;
    fall_cnt_d   = fall_cnt_q;
    resp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d    = SETUP;
          tx_d       = {bus.req_write, bus.req_addr, bus.req_write ? bus.req_wdata : '0};
          fall_cnt_d = '0;
        end
      end
      SETUP: if (half_done) state_d = SHIFT;
      SHIFT: if (half_done && all_falls_done) state_d = HOLD;
      HOLD: begin
        if (half_done) begin
          state_d      = GAP;
          resp_valid_d = 1'b1;
          rdata_d      = rx_q;
        end
      end
      GAP:     if (half_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fall_en) begin
      fall_cnt_d = fall_cnt_q + BIT_CNT_W'(1);
      if (!last_fall) tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
    end
    if (capture_en) rx_d = {rx_q[PDATA_WIDTH-2:0], rx_bit};
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      rdata_q      <= '0;
      fall_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      rdata_q      <= rdata_d;
      fall_cnt_q   <= fall_cnt_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.ss         = !in_frame;
  assign bus.mosi       = in_frame ? tx_q[WRITE_BIT] : 1'b0;
  assign bus.sclk       = sclk;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_spi_master.sv
// Self-checking bench: drives register frames into two dividers of the SPI
// master and checks the pins against frame/timing expectations and a mode-0 slave.
module tb_gpio_spi_master;

`ifdef GPIO_SPI_MISO_SYNC_EN
  localparam int DIV_A = 3;
  localparam int DIV_B = 4;
`else
  localparam int DIV_A = 2;
  localparam int DIV_B = 1;
`endif

  logic       clk;
  logic       reset;
  logic       sel;
  logic       req_valid, req_write, miso;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       o_ready, o_resp_valid, o_sclk, o_ss, o_mosi;
  logic [7:0] o_rdata;

  int vectors;
  int miscompares;
  int cyc_now;

  gpio_spi_if #(.ADDR_WIDTH(7), .PDATA_WIDTH(8)) bus_a ();
  gpio_spi_if #(.ADDR_WIDTH(7), .PDATA_WIDTH(8)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_write = req_write;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_a.miso      = miso;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_write = req_write;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_wdata = req_wdata;
  assign bus_b.miso      = miso;

  gpio_spi_master #(.CLK_DIV(DIV_A), .ADDR_WIDTH(7), .PDATA_WIDTH(8)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.master)
  );

  gpio_spi_master #(.CLK_DIV(DIV_B), .ADDR_WIDTH(7), .PDATA_WIDTH(8)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.master)
  );

  always_comb begin
    o_ready      = sel ? bus_b.req_ready  : bus_a.req_ready;
    o_resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
    o_rdata      = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
    o_sclk       = sel ? bus_b.sclk       : bus_a.sclk;
    o_ss         = sel ? bus_b.ss         : bus_a.ss;
    o_mosi       = sel ? bus_b.mosi       : bus_a.mosi;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  function automatic int cur_div();
    return sel ? DIV_B : DIV_A;
  endfunction

  task automatic pulse_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
  endtask

  // One complete frame: wait for ready, issue the request, act as a mode-0
  // slave returning {random, sdata}, and check pins and timing until ready returns.
  task automatic do_frame(input string name, input logic wr, input logic [6:0] addr,
                          input logic [7:0] wdata, input logic [7:0] sdata, input bit keep_valid,
                          output int wait_cyc, output int t_fall, output int t_rise);
    int d, rises, ss_low, resp_cnt, resp_cyc, ready_cyc, first_rise, first_low, idx, limit;
    logic [15:0] exp_frame, got_frame, slave_word;
    logic [7:0]  got_rdata;
    logic        prev_sclk, prev_ss;
    bit          gap_ok;
    d          = cur_div();
    exp_frame  = {wr, addr, wr ? wdata : 8'h00};
    slave_word = {8'($urandom), sdata};
    t_fall     = -1;
    t_rise     = -1;
    wait_cyc   = 0;
    while (!o_ready && wait_cyc < 60 * d + 20) begin
      step();
      wait_cyc++;
    end
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_wait: req_ready=%b after %0d cycles, expected 1", name, o_ready, wait_cyc);
      return;
    end

    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = keep_valid;
    req_write = 1'($urandom);
    req_addr  = 7'($urandom);
    req_wdata = 8'($urandom);

    got_frame = '0; got_rdata = '0; rises = 0; ss_low = 0; resp_cnt = 0; idx = 0;
    resp_cyc = -1; ready_cyc = -1; first_rise = -1; first_low = -1;
    prev_sclk = 1'b0; prev_ss = 1'b1; gap_ok = 1'b1;
    limit = 40 * d + 10;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (cyc > 1) step();
      if (!o_ss) begin
        ss_low++;
        if (first_low < 0) begin
          first_low = cyc;
          t_fall    = cyc_now;
        end
      end
      if (o_ss && !prev_ss && t_rise < 0) t_rise = cyc_now;
      if (o_sclk && !prev_sclk) begin
        rises++;
        got_frame = {got_frame[14:0], o_mosi};
        if (first_rise < 0) first_rise = cyc;
      end
      if (!o_ss && prev_sclk && !o_sclk) idx++;
      miso = (!o_ss && idx < 16) ? slave_word[15-idx] : 1'($urandom);
      if (o_resp_valid) begin
        resp_cnt++;
        resp_cyc  = cyc;
        got_rdata = o_rdata;
        if (o_sclk || o_mosi || !o_ss) gap_ok = 1'b0;
      end
      prev_sclk = o_sclk;
      prev_ss   = o_ss;
      if (o_ready) begin
        ready_cyc = cyc;
        break;
      end
    end

    vectors++; if (first_low != 1) begin miscompares++; $display("FAIL %s ss_fall_cycle: got %0d expected 1", name, first_low); end
    vectors++; if (ss_low != 34 * d) begin miscompares++; $display("FAIL %s ss_low_cycles: got %0d expected %0d", name, ss_low, 34 * d); end
    vectors++; if (first_rise != 1 + d) begin miscompares++; $display("FAIL %s first_rise_cycle: got %0d expected %0d", name, first_rise, 1 + d); end
    vectors++; if (rises != 16) begin miscompares++; $display("FAIL %s sclk_rises: got %0d expected 16", name, rises); end
    vectors++; if (got_frame !== exp_frame) begin miscompares++; $display("FAIL %s mosi_frame: got %h expected %h", name, got_frame, exp_frame); end
    vectors++; if (resp_cnt != 1) begin miscompares++; $display("FAIL %s resp_count: got %0d expected 1", name, resp_cnt); end
    vectors++; if (resp_cyc != 34 * d + 1) begin miscompares++; $display("FAIL %s resp_cycle: got %0d expected %0d", name, resp_cyc, 34 * d + 1); end
    vectors++; if (got_rdata !== sdata) begin miscompares++; $display("FAIL %s resp_rdata: got %h expected %h", name, got_rdata, sdata); end
    vectors++; if (!gap_ok) begin miscompares++; $display("FAIL %s gap_pins: sclk/mosi/ss wrong during resp_valid, expected 0/0/1", name); end
    vectors++; if (ready_cyc != 35 * d + 1) begin miscompares++; $display("FAIL %s ready_cycle: got %0d expected %0d", name, ready_cyc, 35 * d + 1); end
    vectors++; if (o_rdata !== sdata) begin miscompares++; $display("FAIL %s rdata_hold: got %h expected %h", name, o_rdata, sdata); end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (3) step();
    vectors++; if (o_sclk !== 1'b0) begin miscompares++; $display("FAIL reset sclk: got %b expected 0", o_sclk); end
    vectors++; if (o_ss !== 1'b1) begin miscompares++; $display("FAIL reset ss: got %b expected 1", o_ss); end
    vectors++; if (o_mosi !== 1'b0) begin miscompares++; $display("FAIL reset mosi: got %b expected 0", o_mosi); end
    vectors++; if (o_resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset resp_valid: got %b expected 0", o_resp_valid); end
    vectors++; if (o_rdata !== 8'h00) begin miscompares++; $display("FAIL reset resp_rdata: got %h expected 00", o_rdata); end
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset ready_in_reset: got %b expected 0", o_ready); end
    reset = 1'b0;
    #1;
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset ready_after: got %b expected 1", o_ready); end
  endtask

  task automatic test_write();
    int w, tf, tr;
    do_frame("write_20_81", 1'b1, 7'h20, 8'h81, 8'($urandom), 1'b0, w, tf, tr);
  endtask

  task automatic test_read();
    int w, tf, tr;
    do_frame("read_20_5a", 1'b0, 7'h20, 8'($urandom), 8'h5A, 1'b0, w, tf, tr);
    do_frame("read_c3", 1'b0, 7'($urandom), 8'($urandom), 8'hC3, 1'b0, w, tf, tr);
  endtask

  task automatic test_back_to_back();
    int w1, tf1, tr1, w2, tf2, tr2, d;
    d = cur_div();
    do_frame("b2b_write", 1'b1, 7'h21, 8'h0F, 8'($urandom), 1'b1, w1, tf1, tr1);
    do_frame("b2b_read", 1'b0, 7'h21, 8'($urandom), 8'($urandom), 1'b0, w2, tf2, tr2);
    vectors++; if (w2 != 0) begin miscompares++; $display("FAIL b2b accept_wait: got %0d expected 0", w2); end
    vectors++; if (tf2 - tr1 < d) begin miscompares++; $display("FAIL b2b ss_high_gap: got %0d expected >= %0d", tf2 - tr1, d); end
  endtask

  task automatic test_reset_mid_frame();
    int rises, d, w, tf, tr;
    logic prev;
    d = cur_div();
    for (int n = 0; n < 60 * d && !o_ready; n++) step();
    req_valid = 1'b1;
    req_write = 1'($urandom);
    req_addr  = 7'($urandom);
    req_wdata = 8'($urandom);
    step();
    req_valid = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 20 * d && rises < 7; n++) begin
      step();
      miso = 1'($urandom);
      if (o_sclk && !prev) rises++;
      prev = o_sclk;
    end
    vectors++; if (rises != 7) begin miscompares++; $display("FAIL abort sclk_rises_before: got %0d expected 7", rises); end
    reset = 1'b1;
    #1;
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL abort ready_in_reset: got %b expected 0", o_ready); end
    step();
    vectors++; if (o_ss !== 1'b1) begin miscompares++; $display("FAIL abort ss: got %b expected 1", o_ss); end
    vectors++; if (o_sclk !== 1'b0) begin miscompares++; $display("FAIL abort sclk: got %b expected 0", o_sclk); end
    vectors++; if (o_mosi !== 1'b0) begin miscompares++; $display("FAIL abort mosi: got %b expected 0", o_mosi); end
    vectors++; if (o_resp_valid !== 1'b0) begin miscompares++; $display("FAIL abort resp_valid: got %b expected 0", o_resp_valid); end
    vectors++; if (o_rdata !== 8'h00) begin miscompares++; $display("FAIL abort resp_rdata: got %h expected 00", o_rdata); end
    reset = 1'b0;
    #1;
    do_frame("post_abort", 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, w, tf, tr);
    vectors++; if (w != 0) begin miscompares++; $display("FAIL abort accept_wait: got %0d expected 0", w); end
  endtask

  task automatic test_random();
    int w, tf, tr;
    for (int i = 0; i < 8; i++)
      do_frame("random", 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, w, tf, tr);
  endtask

  task automatic test_clkdiv_b();
    int w, tf, tr;
    sel = 1'b1;
    pulse_reset();
    do_frame("div_b_read_a5", 1'b0, 7'($urandom), 8'($urandom), 8'hA5, 1'b0, w, tf, tr);
    for (int i = 0; i < 3; i++)
      do_frame("div_b_random", 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, w, tf, tr);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc_now     = 0;
    sel         = 1'b0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    miso        = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_clkdiv_b();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
